// File: rtl/conv_stream_ctrl.sv
// conv_stream_ctrl: frame sequencer wrapped around a streaming convolution
// datapath. It clears the datapath history once per frame, meters input
// samples into the datapath one at a time, and presents each result on a
// valid/ready output stream. A warm flag marks results computed before the
// receptive field has filled. The datapath values themselves pass straight
// through: conv_x is s_data and m_data is conv_y.
module conv_stream_ctrl #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LEN_W  = 8,
    parameter int unsigned RF     = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  frame_len,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              conv_clr,
    output logic              conv_en,
    output logic [DATA_W-1:0] conv_x,
    input  logic [DATA_W-1:0] conv_y,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready,
    output logic              m_warm,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    // Results with out_cnt below this were computed on a partially filled window.
    localparam logic [LEN_W-1:0] WARM_OUTS = LEN_W'(RF - 1);
    localparam logic [LEN_W-1:0] ONE       = LEN_W'(1);

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   in_cnt_q, in_cnt_d;
    logic [LEN_W-1:0]   out_cnt_q, out_cnt_d;
    logic               m_valid_q, m_valid_d;

    logic               in_fire;
    logic               out_fire;
    logic               last_in;
    logic               last_out;

    // Handshake qualifiers shared by the next-state, counter and output logic.
    always_comb begin
        out_fire = m_valid_q && m_ready;
        // Accept a sample only when the single output slot is free or is
        // being emptied this cycle; this keeps 1 sample/cycle under m_ready=1
        // and freezes the datapath while the consumer stalls.
        s_ready  = (state_q == S_RUN) && (in_cnt_q < len_q) && (!m_valid_q || m_ready);
        in_fire  = s_valid && s_ready;
        last_in  = in_fire && (in_cnt_q == len_q - ONE);
        last_out = out_fire && (out_cnt_q == len_q - ONE);
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned; a missing default would infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start)            state_d = S_CLEAR;
            S_CLEAR: state_d = (len_q == '0) ? S_IDLE : S_RUN;
            S_RUN:   if (last_in)          state_d = S_DRAIN;
            S_DRAIN: if (last_out)         state_d = S_IDLE;
            default:                       state_d = S_IDLE;
        endcase
    end

    // Frame length latch, sample counters and the output-valid flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_q     <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            m_valid_q <= 1'b0;
        end else begin
            len_q     <= len_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            m_valid_q <= m_valid_d;
        end
    end

    // Counter / valid next values: a new frame restarts everything, otherwise
    // each input accept and each output accept advances its own counter.
    always_comb begin
        len_d     = len_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        m_valid_d = m_valid_q;
        if (state_q == S_IDLE) begin
            if (start) begin
                len_d     = frame_len;
                in_cnt_d  = '0;
                out_cnt_d = '0;
                m_valid_d = 1'b0;
            end
        end else begin
            if (in_fire) begin
                in_cnt_d = in_cnt_q + ONE;
            end
            if (out_fire) begin
                out_cnt_d = out_cnt_q + ONE;
            end
            // A simultaneous input accept refills the slot being emptied.
            if (in_fire) begin
                m_valid_d = 1'b1;
            end else if (out_fire) begin
                m_valid_d = 1'b0;
            end
        end
    end

    // Output decode.
    always_comb begin
        conv_clr = (state_q == S_CLEAR);
        conv_en  = in_fire;
        conv_x   = s_data;
        m_valid  = m_valid_q;
        m_data   = conv_y;
        m_warm   = m_valid_q && (out_cnt_q < WARM_OUTS);
        busy     = (state_q != S_IDLE);
        done     = ((state_q == S_CLEAR) && (len_q == '0))
                || ((state_q == S_DRAIN) && last_out);
    end

endmodule
